// File: rtl/inst_fetcher_pkg.sv
// Shared core constants: widths, opcodes, BHT counter format and immediate decoders.
package inst_fetcher_pkg;
  localparam int ADDR_WID  = 32;
  localparam int INST_WID  = 32;
  localparam int DATA_WID  = 32;
  localparam int BHT_CNT_W = 2;

  localparam logic [BHT_CNT_W-1:0] BHT_INIT = 2'b01;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [ADDR_WID-1:0] j_imm(input logic [INST_WID-1:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [ADDR_WID-1:0] b_imm(input logic [INST_WID-1:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/inst_fetcher_bht.sv
// Bimodal branch history table: 2-bit saturating counters, async read, sync update.
module inst_fetcher_bht
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);
  localparam int N = 1 << IDX_W;

  logic [N-1:0][BHT_CNT_W-1:0] cnt;

  // Read sees the pre-update value when both ports hit the same entry.
  assign rd_taken = cnt[rd_idx][BHT_CNT_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= {N{BHT_INIT}};
    end else if (en && upd) begin
      if (upd_taken && cnt[upd_idx] != '1)
        cnt[upd_idx] <= cnt[upd_idx] + 1'b1;
      else if (!upd_taken && cnt[upd_idx] != '0)
        cnt[upd_idx] <= cnt[upd_idx] - 1'b1;
    end
  end
endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: PC, icache request, next-PC prediction (JAL / bimodal branch), issue to decoder.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                  BHT_IDX_W = 8,
  parameter logic [ADDR_WID-1:0] RESET_PC  = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  output logic                icache_req,
  output logic [ADDR_WID-1:0] icache_addr,
  input  logic                icache_done,
  input  logic [INST_WID-1:0] icache_inst,
  input  logic                stall,
  output logic                inst_rdy,
  output logic [INST_WID-1:0] inst,
  output logic [ADDR_WID-1:0] inst_pc,
  output logic                inst_pred_jump,
  input  logic                rollback,
  input  logic [ADDR_WID-1:0] rollback_pc,
  input  logic                br_update,
  input  logic [ADDR_WID-1:0] br_pc,
  input  logic                br_taken
);
  localparam logic [0:0] S_FETCH = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]          state;
  logic [ADDR_WID-1:0] pc;
  logic [ADDR_WID-1:0] npc;
  logic [INST_WID-1:0] hold_inst;
  logic [INST_WID-1:0] cur_inst;
  logic                bht_taken;
  logic                pred_jump;
  logic                issue;
  logic                unused_br_bits;

  assign unused_br_bits = ^{br_pc[ADDR_WID-1:BHT_IDX_W+2], br_pc[1:0]};

  inst_fetcher_bht #(.IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (rdy),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_taken  (bht_taken),
    .upd       (br_update),
    .upd_idx   (br_pc[BHT_IDX_W+1:2]),
    .upd_taken (br_taken)
  );

  // Rollback drops the request in the same cycle so the cache abandons it.
  assign icache_req  = rst_n && (state == S_FETCH) && !rollback;
  assign icache_addr = pc;

  assign issue = !rollback && !stall &&
                 ((state == S_FETCH && icache_done) || state == S_HOLD);

  always_comb begin
    cur_inst  = (state == S_HOLD) ? hold_inst : icache_inst;
    npc       = pc + 32'd4;
    pred_jump = 1'b0;
    case (cur_inst[6:0])
      OPC_JAL: begin
        npc       = pc + j_imm(cur_inst);
        pred_jump = 1'b1;
      end
      OPC_BRANCH: begin
        if (bht_taken) begin
          npc       = pc + b_imm(cur_inst);
          pred_jump = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_FETCH;
      pc             <= RESET_PC;
      hold_inst      <= '0;
      inst_rdy       <= 1'b0;
      inst           <= '0;
      inst_pc        <= '0;
      inst_pred_jump <= 1'b0;
    end else if (rdy) begin
      if (rollback) begin
        pc       <= rollback_pc;
        inst_rdy <= 1'b0;
        state    <= S_FETCH;
      end else begin
        inst_rdy <= issue;
        if (issue) begin
          inst           <= cur_inst;
          inst_pc        <= pc;
          inst_pred_jump <= pred_jump;
          pc             <= npc;
          state          <= S_FETCH;
        end else if (state == S_FETCH && icache_done) begin
          hold_inst <= icache_inst;
          state     <= S_HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed test-plan scenarios plus a randomized run against a behavioural fetch model.
module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_done;
  logic [31:0] icache_inst;
  logic        stall;
  logic        inst_rdy;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_pred_jump;
  logic        rollback;
  logic [31:0] rollback_pc;
  logic        br_update;
  logic [31:0] br_pc;
  logic        br_taken;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc, m_hold_w, m_inst, m_ipc;
  bit          m_hold, m_ordy, m_pj;
  int          m_bht[256];

  inst_fetcher #(.BHT_IDX_W(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_done(icache_done), .icache_inst(icache_inst),
    .stall(stall), .inst_rdy(inst_rdy), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_jump(inst_pred_jump), .rollback(rollback), .rollback_pc(rollback_pc),
    .br_update(br_update), .br_pc(br_pc), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_hold = 0; m_ordy = 0; m_inst = 0; m_ipc = 0; m_pj = 0; m_hold_w = 0;
    for (int i = 0; i < 256; i++) m_bht[i] = 1;
  endtask

  function automatic int jimm(input logic [31:0] w);
    int v;
    v = int'((w >> 21) & 32'h3ff) * 2 + int'((w >> 20) & 32'h1) * 2048 +
        int'((w >> 12) & 32'hff) * 4096;
    if (w[31]) v = v - (1 << 20);
    return v;
  endfunction

  function automatic int bimm(input logic [31:0] w);
    int v;
    v = int'((w >> 8) & 32'hf) * 2 + int'((w >> 25) & 32'h3f) * 32 +
        int'((w >> 7) & 32'h1) * 2048;
    if (w[31]) v = v - 4096;
    return v;
  endfunction

  task automatic model_step();
    logic [31:0] w, tgt;
    bit pj;
    int bi;
    if (!rdy) return;
    w   = m_hold ? m_hold_w : icache_inst;
    tgt = m_pc + 32'd4;
    pj  = 0;
    if (w[6:0] == 7'h6f) begin
      tgt = m_pc + jimm(w); pj = 1;
    end else if (w[6:0] == 7'h63 && m_bht[(m_pc >> 2) & 255] >= 2) begin
      tgt = m_pc + bimm(w); pj = 1;
    end
    if (rollback) begin
      m_pc = rollback_pc; m_ordy = 0; m_hold = 0;
    end else if ((m_hold || icache_done) && !stall) begin
      m_ordy = 1; m_inst = w; m_ipc = m_pc; m_pj = pj; m_pc = tgt; m_hold = 0;
    end else begin
      m_ordy = 0;
      if (!m_hold && icache_done) begin m_hold = 1; m_hold_w = icache_inst; end
    end
    if (br_update) begin
      bi = int'((br_pc >> 2) & 32'hff);
      if (br_taken) m_bht[bi] = (m_bht[bi] < 3) ? m_bht[bi] + 1 : 3;
      else          m_bht[bi] = (m_bht[bi] > 0) ? m_bht[bi] - 1 : 0;
    end
  endtask

  // One clock: drive, check combinational request mid-cycle, then registered outputs after the edge.
  task automatic cyc(input bit r, input bit d, input logic [31:0] w, input bit s,
                     input bit rb, input logic [31:0] rbpc,
                     input bit bu, input logic [31:0] bpc, input bit bt);
    bit exp_req;
    rdy = r; icache_done = d; icache_inst = w; stall = s;
    rollback = rb; rollback_pc = rbpc; br_update = bu; br_pc = bpc; br_taken = bt;
    @(negedge clk);
    exp_req = !m_hold && !rb;
    chk("icache_req", {31'b0, icache_req}, {31'b0, exp_req});
    if (exp_req) chk("icache_addr", icache_addr, m_pc);
    model_step();
    @(posedge clk); #1;
    chk("inst_rdy", {31'b0, inst_rdy}, {31'b0, m_ordy});
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("pred_jump", {31'b0, inst_pred_jump}, {31'b0, m_pj});
  endtask

  task automatic fetch(input logic [31:0] w);
    cyc(1, 1, w, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redirect(input logic [31:0] p);
    cyc(1, 0, 0, 0, 1, p, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] p, input bit t);
    cyc(1, 0, 0, 0, 0, 0, 1, p, t);
  endtask

  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] JAL  = 32'h0100006F;
  localparam logic [31:0] BEQ  = 32'hFE000CE3;  // beq x0,x0,-8

  initial begin
    logic [31:0] w, rbp, bp;
    bit r, d, s, rb, bu;
    rst_n = 0; rdy = 1; icache_done = 0; icache_inst = 0; stall = 0;
    rollback = 0; rollback_pc = 0; br_update = 0; br_pc = 0; br_taken = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, icache_req}, 32'd0);
    chk("rst_inst_rdy", {31'b0, inst_rdy}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_pj", {31'b0, inst_pred_jump}, 32'd0);
    @(negedge clk); rst_n = 1; #1;
    chk("post_rst_req", {31'b0, icache_req}, 32'd1);
    chk("post_rst_addr", icache_addr, 32'd0);
    @(posedge clk); #1;

    // Straight-line fetch
    fetch(ADDI);
    chk("sl_addr4", icache_addr, 32'h4);
    chk("sl_pc0", inst_pc, 32'h0);
    fetch(ADDI);
    chk("sl_addr8", icache_addr, 32'h8);
    chk("sl_pc4", inst_pc, 32'h4);

    // JAL
    redirect(32'h10);
    fetch(JAL);
    chk("jal_addr", icache_addr, 32'h20);
    chk("jal_pj", {31'b0, inst_pred_jump}, 32'd1);

    // Branch training
    redirect(32'h40);
    fetch(BEQ);
    chk("br_cold", icache_addr, 32'h44);
    train(32'h40, 1); train(32'h40, 1);
    redirect(32'h40);
    fetch(BEQ);
    chk("br_hot", icache_addr, 32'h38);
    chk("br_hot_pj", {31'b0, inst_pred_jump}, 32'd1);
    repeat (4) train(32'h40, 0);
    train(32'h40, 1);
    redirect(32'h40);
    fetch(BEQ);
    chk("br_sat0", icache_addr, 32'h44);

    // Stall into HOLD, then release
    cyc(1, 1, ADDI, 1, 0, 0, 0, 0, 0);
    chk("hold_req", {31'b0, icache_req}, 32'd0);
    cyc(1, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("hold_no_issue", {31'b0, inst_rdy}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_issue_pc", inst_pc, 32'h44);
    chk("hold_next", icache_addr, 32'h48);

    // Rollback colliding with icache_done
    cyc(1, 1, ADDI, 0, 1, 32'h100, 0, 0, 0);
    chk("rb_no_issue", {31'b0, inst_rdy}, 32'd0);
    chk("rb_addr", icache_addr, 32'h100);

    // rdy freeze
    fetch(ADDI);
    repeat (3) cyc(0, 1, JAL, 0, 0, 0, 0, 0, 0);
    chk("frz_rdy", {31'b0, inst_rdy}, 32'd1);
    chk("frz_pc", icache_addr, 32'h104);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-fetch
    fetch(ADDI);
    #2 rst_n = 0;
    #1;
    chk("arst_rdy", {31'b0, inst_rdy}, 32'd0);
    chk("arst_req", {31'b0, icache_req}, 32'd0);
    chk("arst_pc", inst_pc, 32'd0);
    chk("arst_addr", icache_addr, 32'd0);
    model_reset();
    icache_done = 0; rollback = 0; br_update = 0; stall = 0; rdy = 1;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Randomized run
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 9) != 0);
      d  = !m_hold && ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 3))
        0: w = ADDI;
        1: w = ($urandom & 32'hFFFFF000) | 32'h6F;
        2: w = ($urandom & 32'hFE000F80) | 32'h63;
        default: w = ($urandom & 32'hFFFFF000) | 32'h67;
      endcase
      s   = ($urandom_range(0, 2) == 0);
      rb  = ($urandom_range(0, 19) == 0);
      rbp = 32'($urandom_range(0, 255)) << 2;
      bu  = ($urandom_range(0, 3) == 0);
      bp  = ($urandom_range(0, 1) == 0) ? m_pc : (32'($urandom_range(0, 255)) << 2);
      cyc(r, d, w, s, rb, rbp, bu, bp, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
